// File: rtl/y86_dmem_ctrl.sv
// y86_dmem_ctrl -- Y86-64 data-memory controller with a valid/ready request
// and a one-cycle response pulse.
//
// The block decodes the memory-stage icode and picks the address and write
// data from valA/valE/valP. It commits writes and samples reads on the
// acceptance edge. It can insert WAIT_STATES busy cycles and then returns a
// registered response.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   controller can accept a request (IDLE)
//   icode       Y86 instruction code of the request
//   valA        operand A (store data; address for ret/popq)
//   valE        ALU result (address for rmmovq/mrmovq/call/pushq)
//   valP        next PC (store data for call)
//   resp_valid  one-cycle response pulse
//   resp_rdata  read data (valM), held until the next response
//   resp_error  dmem_error for this response, held until the next response
//   busy        request in flight (BUSY or RESP)
module y86_dmem_ctrl #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              accept;
  logic              is_wr, is_rd, addr_err;
  logic [DATA_W-1:0] addr, wdata;
  logic [AW-1:0]     idx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_hold;   // raw array read, captured at acceptance
  logic              rd_use;    // rd_hold is the valid result (legal read)
  logic              err_hold;

  // Operation decode
  always_comb begin
    is_wr = 1'b0;
    is_rd = 1'b0;
    addr  = valE;
    wdata = valA;
    case (icode)
      4'h4:       is_wr = 1'b1;                    // rmmovq
      4'h8:       begin is_wr = 1'b1; wdata = valP; end  // call
      4'hA:       is_wr = 1'b1;                    // pushq
      4'h5:       is_rd = 1'b1;                    // mrmovq
      4'h9, 4'hB: begin is_rd = 1'b1; addr = valA; end   // ret, popq
      default:    ;                                // no memory access
    endcase
  end

  // Full-width unsigned compare. Any set upper bit, including a negative
  // pointer, lands out of range.
  assign addr_err = (is_wr || is_rd) && (addr >= DEPTH_W);
  assign idx      = addr[AW-1:0];
  assign accept   = req_valid && (state == IDLE);

  // The array has no reset, which keeps it inferable as block RAM. The read
  // result is masked by rd_use instead of being cleared here.
  always_ff @(posedge clk) begin
    if (accept && is_wr && !addr_err) begin
      mem[idx] <= wdata;
    end
    if (accept && is_rd) begin
      rd_hold <= mem[idx];
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_next = BUSY;
            cnt_next   = WS_LOAD;
          end else begin
            state_next = RESP;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response outputs are loaded from the holding registers while in RESP,
  // so the pulse and data come straight from flops one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rd_use     <= 1'b0;
      err_hold   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      resp_valid <= (state == RESP);
      if (accept) begin
        rd_use   <= is_rd && !addr_err;
        err_hold <= addr_err;
      end
      if (state == RESP) begin
        resp_rdata <= rd_use ? rd_hold : '0;
        resp_error <= err_hold;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_y86_dmem_ctrl.sv
// Scoreboard bench for y86_dmem_ctrl. Three instances run with 0, 3 and 5
// wait states. One driver issues requests to one instance at a time. For each
// request, a memory model computes the expected response and its arrival
// cycle and pushes them into a queue. Per-instance monitors pop and compare
// whenever resp_valid is seen.
module tb_y86_dmem_ctrl;

  localparam int NI = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n_s     [NI];
  logic        req_valid_s [NI];
  logic        req_ready_s [NI];
  logic        resp_valid_s[NI];
  logic [63:0] resp_rdata_s[NI];
  logic        resp_error_s[NI];
  logic        busy_s      [NI];
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;

  typedef struct {
    int          k;
    logic [63:0] rdata;
    bit          err;
    bit          chk_data;
    longint      cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [63:0] model_mem [int];

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 5;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    y86_dmem_ctrl #(
      .DATA_W(64), .DEPTH(256),
      .WAIT_STATES((gi == 0) ? 0 : (gi == 1) ? 3 : 5)
    ) u_dut (
      .clk(clk), .rst_n(rst_n_s[gi]),
      .req_valid(req_valid_s[gi]), .req_ready(req_ready_s[gi]),
      .icode(icode), .valA(valA), .valE(valE), .valP(valP),
      .resp_valid(resp_valid_s[gi]), .resp_rdata(resp_rdata_s[gi]),
      .resp_error(resp_error_s[gi]), .busy(busy_s[gi])
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (resp_valid_s[gi] === 1'b1) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_resp inst%0d: resp_valid=1 at cycle %0d, expected none", gi, cyc);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("resp_inst%0d_owner", gi), 64'(gi), 64'(e.k));
          chk($sformatf("resp_inst%0d_cycle", gi), cyc, e.cyc);
          if (e.chk_data) chk($sformatf("resp_inst%0d_rdata", gi), resp_rdata_s[gi], e.rdata);
          chk($sformatf("resp_inst%0d_error", gi), 64'(resp_error_s[gi]), 64'(e.err));
          $display("resp inst%0d cyc=%0d rdata=0x%0h err=%0b (exp 0x%0h/%0b)",
                   gi, cyc, resp_rdata_s[gi], resp_error_s[gi], e.rdata, e.err);
        end
      end
    end
  end

  // Reference model: operation rules applied to an associative memory.
  task automatic model(int k, logic [3:0] ic, logic [63:0] a, logic [63:0] e,
                       logic [63:0] p, output exp_t x);
    bit          wr = 0, rd = 0;
    logic [63:0] addr = e, data = a;
    int          key;
    x.k = k; x.rdata = 64'd0; x.err = 0; x.chk_data = 1; x.cyc = 0;
    case (ic)
      4'h4, 4'hA: wr = 1;
      4'h8:       begin wr = 1; data = p; end
      4'h5:       rd = 1;
      4'h9, 4'hB: begin rd = 1; addr = a; end
      default:    ;
    endcase
    if ((wr || rd) && addr >= 64'd256) begin
      x.err = 1;
    end else if (wr || rd) begin
      key = k * 1024 + int'(addr);
      if (wr) model_mem[key] = data;
      else if (model_mem.exists(key)) x.rdata = model_mem[key];
      else x.chk_data = 0;
    end
  endtask

  // Called at a negedge with the instance idle; returns at the negedge where
  // req_ready is high again.
  task automatic do_req(int k, logic [3:0] ic, logic [63:0] a, logic [63:0] e,
                        logic [63:0] p, bit hold);
    exp_t x;
    int   lowc = 0;
    chk($sformatf("ready_before_req_inst%0d", k), 64'(req_ready_s[k]), 64'd1);
    icode = ic; valA = a; valE = e; valP = p;
    req_valid_s[k] = 1'b1;
    model(k, ic, a, e, p, x);
    x.cyc = cyc + 2 + ws_of(k);
    exp_q.push_back(x);
    $display("req  inst%0d cyc=%0d icode=%0h valA=0x%0h valE=0x%0h valP=0x%0h hold=%0b",
             k, cyc, ic, a, e, p, hold);
    @(posedge clk); #1;
    if (!hold) req_valid_s[k] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_s[k] === 1'b1) break;
      lowc++;
      chk($sformatf("busy_inflight_inst%0d", k), 64'(busy_s[k]), 64'd1);
      if (hold) begin
        icode = 4'($urandom_range(0, 15));
        valA  = 64'($urandom_range(0, 255));
        valE  = 64'($urandom_range(0, 255));
        valP  = {$urandom, $urandom};
      end
    end
    chk($sformatf("ready_low_cycles_inst%0d", k), 64'(lowc), 64'(ws_of(k) + 1));
    req_valid_s[k] = 1'b0;
  endtask

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 7)  return 64'($urandom_range(0, 15));
    if (r == 7) return 64'd255;
    if (r == 8) return 64'd256;
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        dummy;
    logic [3:0]  mem_ops [6];
    logic [3:0]  ic;
    logic [63:0] a, e;
    mem_ops[0] = 4'h4; mem_ops[1] = 4'h5; mem_ops[2] = 4'h8;
    mem_ops[3] = 4'h9; mem_ops[4] = 4'hA; mem_ops[5] = 4'hB;
    icode = 4'h0; valA = '0; valE = '0; valP = '0;
    for (int k = 0; k < NI; k++) begin
      rst_n_s[k] = 1'b1; req_valid_s[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < NI; k++) rst_n_s[k] = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst_n_s[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_ready_inst%0d", k), 64'(req_ready_s[k]), 64'd1);
      chk($sformatf("reset_resp_valid_inst%0d", k), 64'(resp_valid_s[k]), 64'd0);
      chk($sformatf("reset_rdata_inst%0d", k), resp_rdata_s[k], 64'd0);
      chk($sformatf("reset_error_inst%0d", k), 64'(resp_error_s[k]), 64'd0);
      chk($sformatf("reset_busy_inst%0d", k), 64'(busy_s[k]), 64'd0);
    end

    // Write then read back, no wait states
    do_req(0, 4'h4, 64'hDEAD_BEEF, 64'd10, 64'd0, 0);
    do_req(0, 4'h5, 64'd0, 64'd10, 64'd0, 0);
    // call/ret at the top legal address, three wait states
    do_req(1, 4'h8, 64'd0, 64'd255, 64'h40, 0);
    do_req(1, 4'h9, 64'd255, 64'd0, 64'd0, 0);
    // Out-of-range accesses leave address 0 alone
    do_req(0, 4'h4, 64'h1234, 64'd0, 64'd0, 0);
    do_req(0, 4'hA, 64'hAAAA, 64'd256, 64'd0, 0);
    do_req(0, 4'hB, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 0);
    do_req(0, 4'h5, 64'd0, 64'd0, 64'd0, 0);
    // No-op with req_valid held through BUSY, then confirm address 5 intact
    do_req(1, 4'h4, 64'h5555, 64'd5, 64'd0, 0);
    do_req(1, 4'h6, 64'h9999, 64'd5, 64'd0, 1);
    do_req(1, 4'h5, 64'd0, 64'd5, 64'd0, 0);

    // Reset during BUSY: no response, committed write survives
    icode = 4'h4; valE = 64'd3; valA = 64'h77; valP = '0;
    req_valid_s[2] = 1'b1;
    model(2, 4'h4, 64'h77, 64'd3, 64'd0, dummy);
    $display("req  inst2 cyc=%0d icode=4 valA=0x77 valE=0x3 (reset while busy)", cyc);
    @(posedge clk); #1;
    req_valid_s[2] = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_busy_before", 64'(busy_s[2]), 64'd1);
    rst_n_s[2] = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 64'(req_ready_s[2]), 64'd1);
    chk("midreset_busy", 64'(busy_s[2]), 64'd0);
    chk("midreset_resp_valid", 64'(resp_valid_s[2]), 64'd0);
    chk("midreset_rdata", resp_rdata_s[2], 64'd0);
    @(negedge clk);
    rst_n_s[2] = 1'b1;
    repeat (8) @(negedge clk);
    do_req(2, 4'h5, 64'd0, 64'd3, 64'd0, 0);

    // Randomized traffic on every instance
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 3) != 0) ic = mem_ops[$urandom_range(0, 5)];
        else ic = 4'($urandom_range(0, 15));
        e = rand_addr();
        a = ($urandom_range(0, 1) == 1) ? rand_addr() : {$urandom, $urandom};
        do_req(k, ic, a, e, {$urandom, $urandom}, bit'($urandom_range(0, 1)));
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
